// File: rtl/rr_mux_nx1.sv
// Registered N:1 channel selector with valid/ready on both sides.
// Picks one producer per cycle (round-robin or explicit sel) into a single output register.
module rr_mux_nx1 #(
  parameter int unsigned n    = 32,
  parameter int unsigned CH   = 4,
  parameter int unsigned MODE = 0,
  parameter int unsigned SW   = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH-1:0]   in_valid,
  input  logic [CH*n-1:0] in_data,
  output logic [CH-1:0]   in_ready,
  input  logic [SW-1:0]   sel,
  output logic            out_valid,
  output logic [n-1:0]    out_data,
  output logic [SW-1:0]   out_grant,
  input  logic            out_ready
);

  localparam logic [SW:0]   CH_W = (SW+1)'(CH);
  localparam logic [SW-1:0] LAST = SW'(CH-1);

  logic [SW-1:0] ptr;
  logic [SW-1:0] g;
  logic [SW:0]   idx;
  logic          any_v;
  logic          acc_en;
  logic          xfer;
  logic [n-1:0]  g_data;

  // Grant selection; the descending scan lets the nearest channel after ptr win.
  always_comb begin
    g     = '0;
    any_v = 1'b0;
    idx   = '0;
    if (MODE == 0) begin
      for (int i = int'(CH) - 1; i >= 0; i--) begin
        idx = {1'b0, ptr} + (SW+1)'(i);
        if (idx >= CH_W) idx = idx - CH_W;
        if (in_valid[idx[SW-1:0]]) begin
          g     = idx[SW-1:0];
          any_v = 1'b1;
        end
      end
    end else if ({1'b0, sel} < CH_W) begin
      g     = sel;
      any_v = in_valid[sel];
    end
  end

  assign acc_en = !out_valid | out_ready;
  assign xfer   = acc_en & any_v & rst_n;

  // One-hot ready towards the granted producer only.
  always_comb begin
    in_ready = '0;
    for (int k = 0; k < int'(CH); k++) begin
      in_ready[k] = xfer && (g == SW'(k));
    end
  end

  always_comb begin
    g_data = '0;
    for (int k = 0; k < int'(CH); k++) begin
      if (g == SW'(k)) g_data = in_data[k*n +: n];
    end
  end

  // Output stage; a new beat overwrites a draining one with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grant <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= g_data;
        out_grant <= g;
        if (MODE == 0) ptr <= (g == LAST) ? '0 : g + SW'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_nx1.sv
// Scoreboard bench for rr_mux_nx1: three configurations (CH=4 RR, CH=3 RR, CH=3 fixed select)
// driven with random and directed traffic against a per-cycle reference model.
module tb_rr_mux_nx1;

  logic clk;
  logic rst_n;
  int   phase;
  int   n_checks;
  int   n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int cfg, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d t=%0t: got 0x%0h expected 0x%0h", nm, cfg, $time, act, exp);
    end
  endtask

  for (genvar c = 0; c < 3; c++) begin : g_cfg
    localparam int unsigned CHC   = (c == 0) ? 4 : 3;
    localparam int unsigned MODEC = (c == 2) ? 1 : 0;
    localparam int unsigned SWC   = $clog2(CHC);

    logic [CHC-1:0]    iv;
    logic [CHC*32-1:0] id;
    logic [CHC-1:0]    ir;
    logic [SWC-1:0]    sel;
    logic              ov;
    logic [31:0]       od;
    logic [SWC-1:0]    og;
    logic              ordy;

    logic [39:0] q[$];
    bit          mv;
    int          mptr;
    logic [31:0] md;
    int          mg;
    bit          fin_done;

    rr_mux_nx1 #(.n(32), .CH(CHC), .MODE(MODEC)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv),
      .in_data   (id),
      .in_ready  (ir),
      .sel       (sel),
      .out_valid (ov),
      .out_data  (od),
      .out_grant (og),
      .out_ready (ordy)
    );

    // Reference arbitration: first valid channel walking forward from the pointer modulo CH.
    function automatic void ref_grant(input logic [CHC-1:0] v, input int p, input int s,
                                      output bit any, output int gr);
      any = 1'b0;
      gr  = 0;
      if (MODEC == 0) begin
        for (int off = 0; off < int'(CHC); off++) begin
          int ch;
          ch = (p + off) % int'(CHC);
          if (!any && v[ch]) begin
            any = 1'b1;
            gr  = ch;
          end
        end
      end else if (s < int'(CHC) && v[s]) begin
        any = 1'b1;
        gr  = s;
      end
    endfunction

    // Stimulus, applied just after each rising edge.
    initial begin
      int st;
      st   = 0;
      iv   = '0;
      id   = '0;
      sel  = '0;
      ordy = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        st = (phase == 4) ? st + 1 : 0;
        case (phase)
          0: begin
            iv = CHC'($urandom);
            for (int k = 0; k < int'(CHC); k++) id[k*32 +: 32] = $urandom;
            sel  = SWC'($urandom);
            ordy = 1'($urandom);
          end
          1: begin
            iv   = '0;
            ordy = 1'($urandom);
          end
          2, 5: begin
            iv = '1;
            for (int k = 0; k < int'(CHC); k++) id[k*32 +: 32] = 32'hA0 + 32'(k);
            sel  = SWC'(1);
            ordy = 1'b1;
          end
          3: begin
            iv = CHC'($urandom);
            for (int k = 0; k < int'(CHC); k++) id[k*32 +: 32] = $urandom;
            sel  = SWC'($urandom_range(0, 3));
            ordy = ($urandom_range(0, 9) < 7);
          end
          4: begin
            iv   = '0;
            ordy = 1'b1;
            if (c == 0) begin
              if (st == 4) begin
                iv = CHC'(4);
                id[64 +: 32] = 32'hDEAD_BEEF;
                ordy = 1'b0;
              end else if (st >= 5 && st <= 9) begin
                iv   = CHC'(3);
                ordy = 1'b0;
              end else if (st == 10) begin
                iv = CHC'(3);
              end
            end
          end
          default: begin
            iv   = '0;
            ordy = 1'b1;
          end
        endcase
      end
    end

    // Reference model: checks present state, then predicts the coming edge.
    always @(negedge clk) begin
      bit             any;
      bit             acc;
      int             gr;
      logic [CHC-1:0] e_ir;
      if (!rst_n) begin
        mv   = 1'b0;
        mptr = 0;
        md   = '0;
        mg   = 0;
        q.delete();
      end
      ref_grant(iv, mptr, int'(sel), any, gr);
      acc  = !mv || ordy;
      e_ir = '0;
      if (rst_n && acc && any) e_ir[gr] = 1'b1;
      chk("out_valid", c, 64'(ov), 64'(mv));
      chk("out_data", c, 64'(od), 64'(md));
      chk("out_grant", c, 64'(og), 64'(mg));
      chk("in_ready", c, 64'(ir), 64'(e_ir));
      if (rst_n && acc && any) begin
        md = id[gr*32 +: 32];
        mg = gr;
        mv = 1'b1;
        q.push_back({md, 8'(gr)});
        if (MODEC == 0) mptr = (gr + 1) % int'(CHC);
      end else if (rst_n && ordy) begin
        mv = 1'b0;
      end
      if (phase == 9 && !fin_done) begin
        fin_done = 1'b1;
        chk("queue_drained", c, 64'(q.size()), 64'd0);
      end
    end

    // Monitor: every beat the consumer takes must match the oldest predicted beat.
    always @(negedge clk) begin
      logic [39:0] b;
      if (rst_n && ov && ordy) begin
        chk("beat_predicted", c, 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          b = q.pop_front();
          chk("sb_data", c, 64'(od), 64'(b[39:8]));
          chk("sb_grant", c, 64'(og), 64'(b[7:0]));
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    phase    = 0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    repeat (4) @(posedge clk);
    phase = 1;
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    phase = 2;
    repeat (20) @(posedge clk);
    phase = 3;
    repeat (400) @(posedge clk);
    phase = 4;
    repeat (15) @(posedge clk);
    phase = 5;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    phase = 8;
    repeat (6) @(posedge clk);
    phase = 9;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
